// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU controller.
//   state_t     : controller FSM states
//   NIB_W       : width of one ALU slice (one nibble)
//   S_*         : 74181 function-select codes used by callers
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // 74181 select codes (active-high data). S_SUB and S_XOR share the code;
  // the M bit chooses between them (M=0 arithmetic, M=1 logic).
  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_SUB = 4'b0110;
  localparam logic [3:0] S_XOR = 4'b0110;
  localparam logic [3:0] S_AND = 4'b1011;

endpackage

// File: rtl/nibble_serial_alu_ctrl.sv
// Sequencer that time-shares one external 4-bit 74181-style slice to perform
// a W = 4*NIBBLES bit operation, one nibble per clock, LSB nibble first.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid / req_ready       operand request handshake (ready only in IDLE)
//   op_a, op_b [W-1:0]          operands
//   op_s [3:0], op_m, op_cn     74181 select, mode (1=logic), active-low carry-in
//   slice_a/b [3:0]             current operand nibbles to the slice
//   slice_s [3:0], slice_m      latched select/mode to the slice
//   slice_cn                    active-low carry-in to the slice
//   slice_f [3:0], slice_cn4,   combinational slice results, sampled at the
//   slice_aeqb                  end of each RUN cycle
//   res_valid / res_ready       result handshake (valid only in DONE)
//   result [W-1:0]              assembled F
//   res_cn4                     final active-low carry-out
//   res_aeqb                    AND of every nibble's A=B output
//   dbg_state [1:0]             current FSM state (state_t encoding)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ready on the request side and valid on the result side are pure
// functions of the FSM state; neither depends combinationally on the
// partner's signal. A requester must hold valid and its data until it sees
// ready; the controller holds result/res_cn4/res_aeqb stable while res_valid
// is high.
module nibble_serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NIB_W*NIBBLES-1:0] op_a,
  input  logic [NIB_W*NIBBLES-1:0] op_b,
  input  logic [3:0]               op_s,
  input  logic                     op_m,
  input  logic                     op_cn,
  output logic [3:0]               slice_a,
  output logic [3:0]               slice_b,
  output logic [3:0]               slice_s,
  output logic                     slice_m,
  output logic                     slice_cn,
  input  logic [3:0]               slice_f,
  input  logic                     slice_cn4,
  input  logic                     slice_aeqb,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [NIB_W*NIBBLES-1:0] result,
  output logic                     res_cn4,
  output logic                     res_aeqb,
  output logic [1:0]               dbg_state
);

  localparam int W = NIB_W * NIBBLES;
  localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

  state_t       state, state_d;
  logic [W-1:0] a_sh, b_sh;   // operand nibbles not yet presented, next in [3:0]
  logic [2:0]   idx;          // nibble currently on the slice
  logic         aeqb_acc;
  logic         accept, step, last;

  assign dbg_state = state;

  always_comb begin
    state_d   = state;
    req_ready = 1'b0;
    res_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (idx == LAST_IDX) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // slice_s/slice_m double as the latched select/mode, and slice_cn is the
  // inter-nibble carry register: after each nibble it takes that nibble's
  // Cn+4 so the next nibble sees it as its carry-in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      idx      <= 3'd0;
      aeqb_acc <= 1'b0;
      slice_a  <= 4'd0;
      slice_b  <= 4'd0;
      slice_s  <= 4'd0;
      slice_m  <= 1'b1;
      slice_cn <= 1'b1;
      result   <= '0;
      res_cn4  <= 1'b1;
      res_aeqb <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        // Nibble 0 goes straight onto the slice so it is evaluated in the
        // first RUN cycle.
        slice_a  <= op_a[NIB_W-1:0];
        slice_b  <= op_b[NIB_W-1:0];
        a_sh     <= op_a >> NIB_W;
        b_sh     <= op_b >> NIB_W;
        slice_s  <= op_s;
        slice_m  <= op_m;
        slice_cn <= op_cn;
        idx      <= 3'd0;
        result   <= '0;
        aeqb_acc <= 1'b1;
      end else if (step) begin
        result[NIB_W*idx +: NIB_W] <= slice_f;
        slice_cn <= slice_cn4;
        aeqb_acc <= aeqb_acc & slice_aeqb;
        slice_a  <= a_sh[NIB_W-1:0];
        slice_b  <= b_sh[NIB_W-1:0];
        a_sh     <= a_sh >> NIB_W;
        b_sh     <= b_sh >> NIB_W;
        idx      <= idx + 3'd1;
        if (last) begin
          res_cn4  <= slice_cn4;
          res_aeqb <= aeqb_acc & slice_aeqb;
        end
      end
    end
  end

endmodule
